multi_ctrl: RTL and testbench

MULTI_CTRL -- requirements
Module: multi_ctrl

---
 rtl/multi_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multi_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_ctrl
// Description : Multicycle datapath controller FSM (fetch/decode/lw/sw/R/beq/j)
//               with registered Moore control outputs and optional illegal trap.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_ctrl #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_HALT   = 4'd10;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic c_TRAP = (ILLEGAL_TRAP != 0);

    // Moore control word layout:
    // [12] IorD [11] MemRead [10] MemWrite [9] RegDst [8] MemtoReg [7] RegWrite
    // [6] ALUSrcA [5:4] ALUSrcB [3:2] ALUOp [1:0] PCSource
    function automatic logic [12:0] f_decode(input logic [3:0] s);
        logic [12:0] v;
        v = '0;
        case (s)
            c_FETCH: begin
                v[11]  = 1'b1;
                v[5:4] = 2'b01;
            end
            c_DECODE: v[5:4] = 2'b11;
            c_MEMADR: begin
                v[6]   = 1'b1;
                v[5:4] = 2'b10;
            end
            c_MEMRD: begin
                v[12] = 1'b1;
                v[11] = 1'b1;
            end
            c_MEMWB: begin
                v[8] = 1'b1;
                v[7] = 1'b1;
            end
            c_MEMWR: begin
                v[12] = 1'b1;
                v[10] = 1'b1;
            end
            c_EXEC: begin
                v[6]   = 1'b1;
                v[3:2] = 2'b10;
            end
            c_RWB: begin
                v[9] = 1'b1;
                v[7] = 1'b1;
            end
            c_BRANCH: begin
                v[6]   = 1'b1;
                v[3:2] = 2'b01;
                v[1:0] = 2'b01;
            end
            c_JUMP:  v[1:0] = 2'b10;
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [12:0] r_ctrl;
    logic        w_fetch_done;

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = c_EXEC;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = c_TRAP ? c_HALT : c_FETCH;
                endcase
            end
            c_MEMADR: begin
                if (opcode == c_OP_LW) begin
                    w_next = c_MEMRD;
                end else if (opcode == c_OP_SW) begin
                    w_next = c_MEMWR;
                end else begin
                    w_next = c_FETCH;
                end
            end
            c_MEMRD:  w_next = mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWB:  w_next = c_FETCH;
            c_MEMWR:  w_next = mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_RWB;
            c_RWB:    w_next = c_FETCH;
            c_BRANCH: w_next = c_FETCH;
            c_JUMP:   w_next = c_FETCH;
            c_HALT:   w_next = c_HALT;
            default:  w_next = c_FETCH;
        endcase
    end

    // Control word is loaded from the decode of the next state so outputs
    // stay glitch-free Moore functions of the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FETCH;
            r_ctrl  <= f_decode(c_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
        end
    end

    // Fetch handshake strobes are gated by rst so a ready memory cannot
    // load IR/PC while the controller is held in reset.
    assign w_fetch_done = (r_state == c_FETCH) && mem_ready && !rst;

    assign IRWrite  = w_fetch_done;
    assign PCWrite  = w_fetch_done
                    | ((r_state == c_BRANCH) & zero)
                    | (r_state == c_JUMP);

    assign IorD     = r_ctrl[12];
    assign MemRead  = r_ctrl[11];
    assign MemWrite = r_ctrl[10];
    assign RegDst   = r_ctrl[9];
    assign MemtoReg = r_ctrl[8];
    assign RegWrite = r_ctrl[7];
    assign ALUSrcA  = r_ctrl[6];
    assign ALUSrcB  = r_ctrl[5:4];
    assign ALUOp    = r_ctrl[3:2];
    assign PCSource = r_ctrl[1:0];
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_ctrl
// Description : Scoreboard bench for multi_ctrl, two instances (trap off/on).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pcw0, iord0, mrd0, mwr0, irw0, rdst0, m2r0, rw0, srca0;
    logic [1:0] psrc0, srcb0, aop0;
    logic [3:0] st0;
    logic       pcw1, iord1, mrd1, mwr1, irw1, rdst1, m2r1, rw1, srca1;
    logic [1:0] psrc1, srcb1, aop1;
    logic [3:0] st1;

    multi_ctrl #(.ILLEGAL_TRAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw0), .PCSource(psrc0), .IorD(iord0), .MemRead(mrd0),
        .MemWrite(mwr0), .IRWrite(irw0), .RegDst(rdst0), .MemtoReg(m2r0),
        .RegWrite(rw0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .ALUOp(aop0), .state(st0)
    );

    multi_ctrl #(.ILLEGAL_TRAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .PCSource(psrc1), .IorD(iord1), .MemRead(mrd1),
        .MemWrite(mwr1), .IRWrite(irw1), .RegDst(rdst1), .MemtoReg(m2r1),
        .RegWrite(rw1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ALUOp(aop1), .state(st1)
    );

    logic [18:0] w_obs0;
    logic [18:0] w_obs1;
    assign w_obs0 = {st0, pcw0, irw0, iord0, mrd0, mwr0, rdst0, m2r0, rw0, srca0, srcb0, aop0, psrc0};
    assign w_obs1 = {st1, pcw1, irw1, iord1, mrd1, mwr1, rdst1, m2r1, rw1, srca1, srcb1, aop1, psrc1};

    typedef struct packed {
        logic [5:0] op;
        logic       mr;
        logic       z;
        logic       r;
        logic [3:0] s0;
        logic [3:0] s1;
    } row_t;

    typedef struct packed {
        logic [18:0] e0;
        logic [18:0] e1;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference control table: expected outputs for a state and current inputs.
    function automatic logic [18:0] exp_vec(input logic [3:0] s, input logic mr, input logic z, input logic r);
        logic pcw, irw, iord, mrd, mwr, rdst, m2r, rw, srca;
        logic [1:0] srcb, aop, psrc;
        {pcw, irw, iord, mrd, mwr, rdst, m2r, rw, srca} = '0;
        {srcb, aop, psrc} = '0;
        case (s)
            4'd0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr & ~r; pcw = mr & ~r; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin srca = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin srca = 1'b1; aop = 2'b01; psrc = 2'b01; pcw = z; end
            4'd9:  begin psrc = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {s, pcw, irw, iord, mrd, mwr, rdst, m2r, rw, srca, srcb, aop, psrc};
    endfunction

    function automatic row_t mk(input logic [5:0] op, input logic mr, input logic z,
                                input logic r, input logic [3:0] s0, input logic [3:0] s1);
        row_t t;
        t.op = op; t.mr = mr; t.z = z; t.r = r; t.s0 = s0; t.s1 = s1;
        return t;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, move to the sample point.
    task automatic apply(input row_t t);
        exp_t e;
        opcode    = t.op;
        mem_ready = t.mr;
        zero      = t.z;
        rst       = t.r;
        e.e0 = exp_vec(t.s0, t.mr, t.z, t.r);
        e.e1 = exp_vec(t.s1, t.mr, t.z, t.r);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[4];
        exp_t e;
        rows[0] = mk(6'h00, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        rows[1] = mk(6'h00, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
        rows[2] = mk(6'h00, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        rows[3] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    task automatic test_rtype();
        row_t rows[4];
        exp_t e;
        rows[0] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[2] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd6, 4'd6);
        rows[3] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7);
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL rtype[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    task automatic test_lw_sw();
        row_t rows[12];
        exp_t e;
        rows[0]  = mk(6'h23, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1]  = mk(6'h23, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[2]  = mk(6'h23, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        rows[3]  = mk(6'h23, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3);
        rows[4]  = mk(6'h23, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3);
        rows[5]  = mk(6'h23, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
        rows[6]  = mk(6'h23, 1'b0, 1'b0, 1'b0, 4'd4, 4'd4);
        rows[7]  = mk(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[8]  = mk(6'h2B, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[9]  = mk(6'h2B, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        rows[10] = mk(6'h2B, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5);
        rows[11] = mk(6'h2B, 1'b1, 1'b0, 1'b0, 4'd5, 4'd5);
        for (int i = 0; i < 12; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL lw_sw[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    task automatic test_branch_jump();
        row_t rows[9];
        exp_t e;
        rows[0] = mk(6'h04, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1] = mk(6'h04, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[2] = mk(6'h04, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8);
        rows[3] = mk(6'h04, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        rows[4] = mk(6'h04, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);
        rows[5] = mk(6'h04, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8);
        rows[6] = mk(6'h02, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[7] = mk(6'h02, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[8] = mk(6'h02, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9);
        for (int i = 0; i < 9; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL branch_jump[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    task automatic test_fetch_stall();
        row_t rows[6];
        exp_t e;
        rows[0] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1] = mk(6'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        rows[2] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[3] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[4] = mk(6'h02, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[5] = mk(6'h02, 1'b1, 1'b0, 1'b0, 4'd9, 4'd9);
        for (int i = 0; i < 6; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL fetch_stall[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    // Instance 0 treats 111111 as a no-op, instance 1 traps and stays halted.
    task automatic test_illegal();
        row_t rows[25];
        exp_t e;
        rows[0] = mk(6'h3F, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1] = mk(6'h3F, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
        for (int i = 0; i < 21; i++) begin
            rows[2 + i] = mk(6'h3F, 1'b0, i[0], 1'b0, 4'd0, 4'd10);
        end
        rows[23] = mk(6'h3F, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        rows[24] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 25; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL illegal[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        row_t rows[4];
        row_t post[5];
        exp_t e;
        rows[0] = mk(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        rows[1] = mk(6'h2B, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
        rows[2] = mk(6'h2B, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        rows[3] = mk(6'h2B, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5);
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL async_pre[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
        #1;
        n_tests++;
        if ({st0, mwr0, st1, mwr1} !== {4'd5, 1'b1, 4'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL async_hold got %0d/%b want 5/1", st0, mwr0);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({st0, mwr0, irw0, pcw0, st1, mwr1} !== {4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst got state %0d memwrite %b want state 0 memwrite 0", st0, mwr0);
        end
        advance();
        post[0] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        post[1] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        post[2] = mk(6'h00, 1'b1, 1'b0, 1'b0, 4'd6, 4'd6);
        post[3] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7);
        post[4] = mk(6'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            apply(post[i]);
            e = sb.pop_front();
            n_tests++;
            if ({w_obs0, w_obs1} !== {e.e0, e.e1}) begin
                n_fail++;
                $display("FAIL async_post[%0d] got %h/%h want %h/%h", i, w_obs0, w_obs1, e.e0, e.e1);
            end
            advance();
        end
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch_jump();
        test_fetch_stall();
        test_illegal();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
